spram_cfg_responder: RTL and testbench

SPRAM_CFG_RESPONDER -- requirements
Module: spram_cfg_responder

---
 rtl/spram_cfg_responder.sv | 153 +++++++++++++++
 tb/tb_spram_cfg_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spram_cfg_responder.sv
// Single-port 512x40 RAM with a configurable aspect view (40/20/10-bit words) and
// a post-reset array-clear sequence; ready is low until the array is usable.

module spram_cfg_slice #(
  parameter int SL_W  = 10,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     wr,
  input  logic [$clog2(DEPTH)-1:0] row,
  input  logic [SL_W-1:0]          wd,
  output logic [SL_W-1:0]          rd
);
  logic [SL_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr)     mem[row] <= '0;
    else if (wr) mem[row] <= wd;
  end

  // Combinational read so the registered dataout sees pre-edge contents.
  assign rd = mem[row];
endmodule

module spram_cfg_responder #(
  parameter int MODE       = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] addr,
  input  logic [39:0] datain,
  input  logic        we,
  output logic [39:0] dataout,
  output logic        ready
);
  localparam int NUM_SL = 4;
  localparam int SL_W   = 10;
  localparam int M      = (MODE == 1) ? 1 : (MODE == 2) ? 2 : 0;

  typedef enum logic {INIT, RUN} state_t;

  state_t                        state, state_nxt;
  logic [8:0]                    cnt, cnt_nxt;
  logic                          clr, clr_eff, acc, wr;
  logic [8:0]                    acc_row, mem_row;
  logic [1:0]                    lane;
  logic [NUM_SL-1:0]             sl_sel;
  logic [NUM_SL-1:0][SL_W-1:0]   wd_sl, rd_sl;
  logic [39:0]                   rd_mux;
  logic                          unused_ok;

  assign unused_ok = &{1'b0, addr, datain};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr       = 1'b0;
    case (state)
      INIT: begin
        if (INIT_CLEAR != 0) begin
          clr     = 1'b1;
          cnt_nxt = cnt + 9'd1;
          if (cnt == 9'd511) state_nxt = RUN;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign ready = (state == RUN);
  assign acc   = ready;
  assign wr    = acc & we;
  // Keep the array untouched while reset is held; clearing belongs to INIT only.
  assign clr_eff = clr & ~reset;
  assign mem_row = (state == INIT) ? cnt : acc_row;

  always_comb begin
    acc_row = addr[8:0];
    lane    = 2'd0;
    case (M)
      1: begin
        acc_row = addr[9:1];
        lane    = {1'b0, addr[0]};
      end
      2: begin
        acc_row = addr[10:2];
        lane    = addr[1:0];
      end
      default: ;
    endcase
  end

  // Write data is replicated into every slice; sl_sel picks which slices commit.
  always_comb begin
    sl_sel = '0;
    wd_sl  = '0;
    for (int g = 0; g < NUM_SL; g++) begin
      case (M)
        1: begin
          sl_sel[g] = (lane[0] == g[1]);
          wd_sl[g]  = g[0] ? datain[19:10] : datain[9:0];
        end
        2: begin
          sl_sel[g] = (lane == g[1:0]);
          wd_sl[g]  = datain[9:0];
        end
        default: begin
          sl_sel[g] = 1'b1;
          wd_sl[g]  = datain[g*SL_W +: SL_W];
        end
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (M)
      1:       rd_mux[19:0] = lane[0] ? rd_sl[3:2] : rd_sl[1:0];
      2:       rd_mux[9:0]  = rd_sl[lane];
      default: rd_mux       = rd_sl;
    endcase
  end

  for (genvar g = 0; g < NUM_SL; g++) begin : g_sl
    spram_cfg_slice #(.SL_W(SL_W), .DEPTH(512)) u_sl (
      .clk (clk),
      .clr (clr_eff),
      .wr  (wr & sl_sel[g]),
      .row (mem_row),
      .wd  (wd_sl[g]),
      .rd  (rd_sl[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    dataout <= '0;
    else if (acc) dataout <= rd_mux;
  end
endmodule

// File: tb/tb_spram_cfg_responder.sv
// Drives one access stream into MODE 0/1/2 instances (plus a no-clear MODE 0 one)
// and checks each against a lane-arithmetic reference image of the array.

module tb_spram_cfg_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] addr;
  logic [39:0] datain;
  logic        we;
  logic [39:0] dout0, dout1, dout2, dout3;
  logic        rdy0, rdy1, rdy2, rdy3;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [39:0] mdl [0:2][0:511];

  always #5 clk = ~clk;

  spram_cfg_responder #(.MODE(0), .INIT_CLEAR(1)) dut_m0 (
    .clk(clk), .reset(reset), .addr(addr), .datain(datain), .we(we), .dataout(dout0), .ready(rdy0));
  spram_cfg_responder #(.MODE(1), .INIT_CLEAR(1)) dut_m1 (
    .clk(clk), .reset(reset), .addr(addr), .datain(datain), .we(we), .dataout(dout1), .ready(rdy1));
  spram_cfg_responder #(.MODE(2), .INIT_CLEAR(1)) dut_m2 (
    .clk(clk), .reset(reset), .addr(addr), .datain(datain), .we(we), .dataout(dout2), .ready(rdy2));
  spram_cfg_responder #(.MODE(0), .INIT_CLEAR(0)) dut_nc (
    .clk(clk), .reset(reset), .addr(addr), .datain(datain), .we(we), .dataout(dout3), .ready(rdy3));

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] mdl_rd(input int m, input logic [10:0] a);
    int w, row, ln;
    longint unsigned v;
    w   = 40 >> m;
    row = (int'(a) >> m) % 512;
    ln  = int'(a) % (1 << m);
    v   = 64'(mdl[m][row]);
    return 40'((v >> (ln * w)) & ((64'd1 << w) - 64'd1));
  endfunction

  task automatic mdl_wr(input int m, input logic [10:0] a, input logic [39:0] d);
    int w, row, ln;
    longint unsigned v, msk;
    w   = 40 >> m;
    row = (int'(a) >> m) % 512;
    ln  = int'(a) % (1 << m);
    v   = 64'(mdl[m][row]);
    msk = ((64'd1 << w) - 64'd1) << (ln * w);
    v   = (v & ~msk) | ((64'(d) << (ln * w)) & msk);
    mdl[m][row] = 40'(v);
  endtask

  task automatic mdl_clear();
    for (int m = 0; m < 3; m++)
      for (int r = 0; r < 512; r++) mdl[m][r] = '0;
  endtask

  // One accepted access per call; consecutive calls are back-to-back cycles.
  task automatic access(input logic w, input logic [10:0] a, input logic [39:0] d);
    logic [39:0] e0, e1, e2;
    @(negedge clk);
    we = w; addr = a; datain = d;
    e0 = mdl_rd(0, a); e1 = mdl_rd(1, a); e2 = mdl_rd(2, a);
    @(posedge clk); #1;
    chk("m0_access", dout0, e0);
    chk("m1_access", dout1, e1);
    chk("m2_access", dout2, e2);
    if (w) begin
      mdl_wr(0, a, d); mdl_wr(1, a, d); mdl_wr(2, a, d);
    end
    we = 1'b0;
  endtask

  // Holds a write to addr 0 throughout INIT, which must be ignored by the clearing instances.
  task automatic init_seq();
    int n, e0, e1, e2, e3;
    e0 = 0; e1 = 0; e2 = 0; e3 = 0;
    we = 1'b1; addr = '0; datain = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (n < 600 && (e0 == 0 || e1 == 0 || e2 == 0 || e3 == 0)) begin
      @(posedge clk); #1;
      n++;
      if (e0 == 0 && rdy0) e0 = n;
      if (e1 == 0 && rdy1) e1 = n;
      if (e2 == 0 && rdy2) e2 = n;
      if (e3 == 0 && rdy3) e3 = n;
    end
    chk("ready_edges_m0", 40'(e0), 40'd512);
    chk("ready_edges_m1", 40'(e1), 40'd512);
    chk("ready_edges_m2", 40'(e2), 40'd512);
    chk("ready_edges_noclr", 40'(e3), 40'd1);
    we = 1'b0;
    mdl_clear();
  endtask

  initial begin
    logic [39:0] d;
    logic [10:0] a;
    reset = 1'b0; we = 1'b0; addr = '0; datain = '0;
    mdl_clear();
    #1 reset = 1'b1;
    #1;
    chk("rst_dout_m0", dout0, '0);
    chk("rst_ready_m0", 40'(rdy0), '0);
    chk("rst_ready_m1", 40'(rdy1), '0);

    init_seq();
    access(0, 11'd0, '0);
    chk("row0_cleared_m0", dout0, '0);
    access(0, 11'h123, '0);

    access(1, 11'd5, 40'hA5A5A5A5A5);
    chk("m0_wr5_prior", dout0, '0);
    access(0, 11'd5, '0);
    chk("m0_rd5", dout0, 40'hA5A5A5A5A5);
    chk("noclr_rd5", dout3, 40'hA5A5A5A5A5);

    access(1, 11'd6, 40'h12345);
    access(1, 11'd7, 40'hABCDE);
    access(0, 11'd6, '0);
    chk("m1_rd6", dout1, 40'h0000012345);
    access(0, 11'd7, '0);
    chk("m1_rd7", dout1, 40'h00000ABCDE);
    chk("m1_row3_image", {dut_m1.g_sl[3].u_sl.mem[3], dut_m1.g_sl[2].u_sl.mem[3],
                          dut_m1.g_sl[1].u_sl.mem[3], dut_m1.g_sl[0].u_sl.mem[3]}, 40'hABCDE12345);

    access(1, 11'd4, 40'h001);
    access(1, 11'd5, 40'h002);
    access(1, 11'd6, 40'h004);
    access(1, 11'd7, 40'h3FF);
    access(1, 11'd5, 40'hFFFFFFF155);
    access(0, 11'd4, '0); chk("m2_rd4", dout2, 40'h001);
    access(0, 11'd5, '0); chk("m2_rd5", dout2, 40'h155);
    access(0, 11'd6, '0); chk("m2_rd6", dout2, 40'h004);
    access(0, 11'd7, '0); chk("m2_rd7", dout2, 40'h3FF);

    access(1, 11'h201, 40'hFF);
    access(0, 11'd1, '0);
    chk("m0_alias_rd1", dout0, 40'hFF);

    for (int i = 0; i < 300; i++) begin
      d[31:0]  = $urandom;
      d[39:32] = 8'($urandom);
      a        = 11'($urandom_range(0, 2047));
      access(1'($urandom_range(0, 1)), a, d);
    end

    for (int i = 0; i < 10; i++) access(0, 11'($urandom_range(0, 2047)), '0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midrun_rst_dout_m0", dout0, '0);
    chk("midrun_rst_dout_m1", dout1, '0);
    chk("midrun_rst_ready_m2", 40'(rdy2), '0);
    init_seq();
    access(0, 11'd0, '0);
    chk("reinit_row0_m0", dout0, '0);
    for (int i = 0; i < 20; i++) access(0, 11'($urandom_range(0, 2047)), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
